// File: rtl/alib_fifo_pkg.sv
// Shared definitions for the alib FIFO family: overwrite-mode encodings and
// the address-width helper.
package alib_fifo_pkg;

  localparam int unsigned FIFO_MODE_DROP      = 0;
  localparam int unsigned FIFO_MODE_OVERWRITE = 1;

  // Smallest r with 2**r >= n; evaluated at elaboration for pointer widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alib_sdp_ram.sv
// Simple dual-port, single-clock memory with a registered, read-first read port.
// Only the read register is reset; array contents are left uninitialised.
module alib_sdp_ram
  import alib_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-address read and write returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/alib_circular_fifo_ext.sv
// Circular FIFO with registered read, fill level, almost-full/empty thresholds,
// sticky overflow/underflow flags and an optional overwrite-oldest mode.
module alib_circular_fifo_ext
  import alib_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_TH     = DEPTH - 2,
  parameter int unsigned AE_TH     = 2,
  parameter int unsigned OVERWRITE = FIFO_MODE_DROP,
  localparam int unsigned AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   lvl_t;

  localparam bit OW_EN = (OVERWRITE == FIFO_MODE_OVERWRITE);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic wr_acc;
  logic rd_acc;
  logic ow_pop;
  logic lvl_inc;
  logic lvl_dec;
  logic ovf_set;
  logic unf_set;

  assign full         = (level == lvl_t'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= lvl_t'(AF_TH));
  assign almost_empty = (level <= lvl_t'(AE_TH));

  // A full FIFO with a concurrent read frees the slot wr_ptr points at; the
  // read-first RAM returns the oldest word while the new one lands there.
  always_comb begin
    rd_acc  = rd_en & ~empty;
    wr_acc  = wr_en & (~full | rd_en | OW_EN);
    ow_pop  = wr_en & full & ~rd_en & OW_EN;
    lvl_inc = wr_acc & ~rd_acc & ~full;
    lvl_dec = rd_acc & ~wr_acc;
    ovf_set = wr_en & full & ~rd_en;
    unf_set = rd_en & empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (rd_acc || ow_pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      if (lvl_inc) begin
        level <= level + lvl_t'(1);
      end else if (lvl_dec) begin
        level <= level - lvl_t'(1);
      end
      data_valid <= rd_acc;
      overflow   <= ovf_set | (overflow & ~clr_flags);
      underflow  <= unf_set | (underflow & ~clr_flags);
    end
  end

  alib_sdp_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr),
    .rd_data(data_out)
  );

endmodule
